// File: rtl/syn_sram_arbiter.sv
// SRAM arbiter and access sequencer for the shared 256Kx16 async SRAM.
// Agent 0 (VGA fetch) has fixed top priority. The other agents share the
// remaining bandwidth round-robin.
module syn_sram_arbiter #(
   parameter int unsigned NUM_AGENTS = 3,
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned DATA_W     = 16
) (
   input  logic                         clk_ir,
   input  logic                         rst_ih,
   input  logic [NUM_AGENTS-1:0]        agent_req,
   input  logic [NUM_AGENTS-1:0]        agent_wr,
   input  logic [NUM_AGENTS*ADDR_W-1:0] agent_addr,
   input  logic [NUM_AGENTS*DATA_W-1:0] agent_wdata,
   output logic [NUM_AGENTS-1:0]        agent_ack,
   output logic [NUM_AGENTS-1:0]        agent_rd_valid,
   output logic [DATA_W-1:0]            agent_rdata,
   output logic [ADDR_W-1:0]            sram_addr,
   output logic [DATA_W-1:0]            sram_wdata,
   output logic                         sram_dq_oe,
   input  logic [DATA_W-1:0]            sram_rdata,
   output logic                         sram_ce_n,
   output logic                         sram_oe_n,
   output logic                         sram_we_n,
   output logic                         sram_ub_n,
   output logic                         sram_lb_n
);

   localparam int unsigned PTR_W  = (NUM_AGENTS > 2) ? $clog2(NUM_AGENTS) : 1;
   localparam int unsigned NUM_RR = NUM_AGENTS - 1;

   typedef enum logic [1:0] {IDLE, RD, WR, WR_HOLD} state_t;

   state_t                  state, state_nx;
   logic [PTR_W-1:0]        rr_ptr, rr_ptr_nx;
   logic [PTR_W-1:0]        gnt_idx;
   logic                    gnt_any;
   logic                    xfer;
   logic                    gnt_wr;
   logic [ADDR_W-1:0]       gnt_addr;
   logic [DATA_W-1:0]       gnt_wdata;
   logic [NUM_AGENTS-1:0]   rd_owner, rd_owner_nx;
   logic [ADDR_W-1:0]       addr_nx;
   logic [DATA_W-1:0]       wdata_nx;
   logic                    dq_oe_nx;
   logic                    ce_n_nx, oe_n_nx, we_n_nx, be_n_nx;
   int                      cand;

   // Winner selection: agent 0 first, else first requester at/after rr_ptr among 1..N-1
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      if (agent_req[0]) begin
         gnt_any = 1'b1;
      end else begin
         for (int o = 0; o < int'(NUM_RR); o++) begin
            cand = ((int'(rr_ptr) - 1 + o) % int'(NUM_RR)) + 1;
            if (!gnt_any && agent_req[PTR_W'(cand)]) begin
               gnt_any = 1'b1;
               gnt_idx = PTR_W'(cand);
            end
         end
      end
   end

   // Grant is withheld while the write strobe is active
   assign xfer = gnt_any && (state != WR);

   // Combinational ack (one-hot or zero) and winner payload mux
   always_comb begin
      agent_ack = '0;
      gnt_wr    = 1'b0;
      gnt_addr  = '0;
      gnt_wdata = '0;
      for (int i = 0; i < int'(NUM_AGENTS); i++) begin
         if (gnt_idx == PTR_W'(i)) begin
            agent_ack[i] = xfer;
            gnt_wr       = agent_wr[i];
            gnt_addr     = agent_addr[i*ADDR_W +: ADDR_W];
            gnt_wdata    = agent_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next state, round-robin pointer and next SRAM pin values
   always_comb begin
      state_nx    = IDLE;
      rr_ptr_nx   = rr_ptr;
      rd_owner_nx = '0;
      addr_nx     = sram_addr;
      wdata_nx    = sram_wdata;
      dq_oe_nx    = 1'b0;
      ce_n_nx     = 1'b1;
      oe_n_nx     = 1'b1;
      we_n_nx     = 1'b1;
      be_n_nx     = 1'b1;
      if (xfer) begin
         addr_nx = gnt_addr;
         ce_n_nx = 1'b0;
         be_n_nx = 1'b0;
         if (gnt_wr) begin
            state_nx = WR;
            we_n_nx  = 1'b0;
            dq_oe_nx = 1'b1;
            wdata_nx = gnt_wdata;
         end else begin
            state_nx = RD;
            oe_n_nx  = 1'b0;
            for (int i = 0; i < int'(NUM_AGENTS); i++) begin
               rd_owner_nx[i] = (gnt_idx == PTR_W'(i));
            end
         end
         if (gnt_idx != '0) begin
            rr_ptr_nx = (gnt_idx == PTR_W'(NUM_RR)) ? PTR_W'(1) : gnt_idx + PTR_W'(1);
         end
      end else if (state == WR) begin
         // Release we_n but keep address, data and pad drive for hold/turnaround
         state_nx = WR_HOLD;
         ce_n_nx  = 1'b0;
         be_n_nx  = 1'b0;
         dq_oe_nx = 1'b1;
      end
   end

   // State, pointer and SRAM pin registers
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         state      <= IDLE;
         rr_ptr     <= PTR_W'(1);
         rd_owner   <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_ub_n  <= 1'b1;
         sram_lb_n  <= 1'b1;
      end else begin
         state      <= state_nx;
         rr_ptr     <= rr_ptr_nx;
         rd_owner   <= rd_owner_nx;
         sram_addr  <= addr_nx;
         sram_wdata <= wdata_nx;
         sram_dq_oe <= dq_oe_nx;
         sram_ce_n  <= ce_n_nx;
         sram_oe_n  <= oe_n_nx;
         sram_we_n  <= we_n_nx;
         sram_ub_n  <= be_n_nx;
         sram_lb_n  <= be_n_nx;
      end
   end

   // Read return: capture SRAM data one cycle after the read transfer
   always_ff @(posedge clk_ir or posedge rst_ih) begin
      if (rst_ih) begin
         agent_rd_valid <= '0;
         agent_rdata    <= '0;
      end else begin
         agent_rd_valid <= rd_owner;
         if (|rd_owner) begin
            agent_rdata <= sram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_syn_sram_arbiter.sv
// Directed testbench for syn_sram_arbiter with a simple async SRAM model.
module tb_syn_sram_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 18;
   localparam int unsigned DW = 16;

   logic              clk_ir = 1'b0;
   logic              rst_ih = 1'b1;
   logic [N-1:0]      agent_req   = '0;
   logic [N-1:0]      agent_wr    = '0;
   logic [N*AW-1:0]   agent_addr  = '0;
   logic [N*DW-1:0]   agent_wdata = '0;
   logic [N-1:0]      agent_ack;
   logic [N-1:0]      agent_rd_valid;
   logic [DW-1:0]     agent_rdata;
   logic [AW-1:0]     sram_addr;
   logic [DW-1:0]     sram_wdata;
   logic              sram_dq_oe;
   logic [DW-1:0]     sram_rdata;
   logic              sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   logic [DW-1:0]     mem [0:(1<<AW)-1];

   int n_pass  = 0;
   int n_total = 0;

   always #10 clk_ir = ~clk_ir;

   syn_sram_arbiter #(.NUM_AGENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_ir(clk_ir), .rst_ih(rst_ih),
      .agent_req(agent_req), .agent_wr(agent_wr),
      .agent_addr(agent_addr), .agent_wdata(agent_wdata),
      .agent_ack(agent_ack), .agent_rd_valid(agent_rd_valid), .agent_rdata(agent_rdata),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_dq_oe(sram_dq_oe),
      .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   // SRAM model: combinational read, write committed while ce_n/we_n are low
   assign sram_rdata = mem[sram_addr];
   always @(posedge clk_ir) begin
      if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_wdata;
   end

   task automatic test_reset();
      @(negedge clk_ir);
      n_total++;
      if ({agent_ack, agent_rd_valid} !== 6'b0 || agent_rdata !== 16'h0)
         $display("FAIL reset_agent got ack=%b vld=%b rdata=%h exp 000 000 0000", agent_ack, agent_rd_valid, agent_rdata);
      else n_pass++;
      n_total++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 6'b111110 ||
          sram_addr !== 18'h0 || sram_wdata !== 16'h0)
         $display("FAIL reset_sram got ctl=%b%b%b%b%b oe=%b addr=%h wdata=%h exp 11111 0 0 0",
                  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, sram_addr, sram_wdata);
      else n_pass++;
      rst_ih = 1'b0;
   endtask

   task automatic test_single_read();
      @(negedge clk_ir);
      agent_req = 3'b010; agent_wr = 3'b000; agent_addr[1*AW +: AW] = 18'h00010;
      #1;
      n_total++;
      if (agent_ack !== 3'b010) $display("FAIL rd_ack got=%b exp=010", agent_ack); else n_pass++;
      @(negedge clk_ir);
      agent_req = 3'b000;
      #1;
      n_total++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b0010 || sram_addr !== 18'h00010 || agent_rd_valid !== 3'b000)
         $display("FAIL rd_cycle got ce=%b oe=%b we=%b dq=%b addr=%h vld=%b exp 0 0 1 0 00010 000",
                  sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_addr, agent_rd_valid);
      else n_pass++;
      @(negedge clk_ir);
      n_total++;
      if (agent_rd_valid !== 3'b010 || agent_rdata !== 16'hBEEF || sram_oe_n !== 1'b1)
         $display("FAIL rd_data got vld=%b rdata=%h oe=%b exp 010 beef 1", agent_rd_valid, agent_rdata, sram_oe_n);
      else n_pass++;
      @(negedge clk_ir);
      n_total++;
      if (agent_rd_valid !== 3'b000) $display("FAIL rd_vld_drop got=%b exp=000", agent_rd_valid); else n_pass++;
   endtask

   task automatic test_write_then_read();
      @(negedge clk_ir);
      agent_req = 3'b100; agent_wr = 3'b100;
      agent_addr[2*AW +: AW] = 18'h3FFFF; agent_wdata[2*DW +: DW] = 16'h1234;
      #1;
      n_total++;
      if (agent_ack !== 3'b100) $display("FAIL wr_ack got=%b exp=100", agent_ack); else n_pass++;
      @(negedge clk_ir);
      agent_wr = 3'b000;
      #1;
      n_total++;
      if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_wdata !== 16'h1234 || sram_addr !== 18'h3FFFF || agent_ack !== 3'b000)
         $display("FAIL wr_cycle got we=%b dq=%b wdata=%h addr=%h ack=%b exp 0 1 1234 3ffff 000",
                  sram_we_n, sram_dq_oe, sram_wdata, sram_addr, agent_ack);
      else n_pass++;
      @(negedge clk_ir);
      #1;
      n_total++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b1 || sram_ce_n !== 1'b0 || sram_wdata !== 16'h1234 || agent_ack !== 3'b100)
         $display("FAIL wr_hold got we=%b dq=%b ce=%b wdata=%h ack=%b exp 1 1 0 1234 100",
                  sram_we_n, sram_dq_oe, sram_ce_n, sram_wdata, agent_ack);
      else n_pass++;
      @(negedge clk_ir);
      agent_req = 3'b000;
      #1;
      n_total++;
      if (sram_oe_n !== 1'b0 || sram_dq_oe !== 1'b0) $display("FAIL rbw_rd got oe=%b dq=%b exp 0 0", sram_oe_n, sram_dq_oe);
      else n_pass++;
      @(negedge clk_ir);
      n_total++;
      if (agent_rd_valid !== 3'b100 || agent_rdata !== 16'h1234)
         $display("FAIL rbw_data got vld=%b rdata=%h exp 100 1234", agent_rd_valid, agent_rdata);
      else n_pass++;
      @(negedge clk_ir);
   endtask

   task automatic test_priority();
      @(negedge clk_ir);
      agent_req = 3'b111; agent_wr = 3'b000;
      agent_addr[0*AW +: AW] = 18'h00100; agent_addr[1*AW +: AW] = 18'h00101; agent_addr[2*AW +: AW] = 18'h00102;
      #1;
      n_total++;
      if (agent_ack !== 3'b001) $display("FAIL pri_g0 got=%b exp=001", agent_ack); else n_pass++;
      @(negedge clk_ir);
      agent_req = 3'b110;
      #1;
      n_total++;
      if (agent_ack !== 3'b010) $display("FAIL pri_g1 got=%b exp=010", agent_ack); else n_pass++;
      @(negedge clk_ir);
      agent_req = 3'b100;
      #1;
      n_total++;
      if (agent_ack !== 3'b100 || agent_rd_valid !== 3'b001 || agent_rdata !== 16'hA000)
         $display("FAIL pri_g2 got ack=%b vld=%b rdata=%h exp 100 001 a000", agent_ack, agent_rd_valid, agent_rdata);
      else n_pass++;
      @(negedge clk_ir);
      agent_req = 3'b000;
      n_total++;
      if (agent_rd_valid !== 3'b010 || agent_rdata !== 16'hA001)
         $display("FAIL pri_v1 got vld=%b rdata=%h exp 010 a001", agent_rd_valid, agent_rdata);
      else n_pass++;
      @(negedge clk_ir);
      n_total++;
      if (agent_rd_valid !== 3'b100 || agent_rdata !== 16'hA002)
         $display("FAIL pri_v2 got vld=%b rdata=%h exp 100 a002", agent_rd_valid, agent_rdata);
      else n_pass++;
      @(negedge clk_ir);
   endtask

   task automatic test_round_robin();
      int cnt1 = 0;
      int cnt2 = 0;
      int bad  = 0;
      logic [N-1:0] exp_ack;
      @(negedge clk_ir);
      agent_req = 3'b110; agent_wr = 3'b000;
      for (int i = 0; i < 20; i++) begin
         #1;
         exp_ack = (i % 2 == 0) ? 3'b010 : 3'b100;
         if (agent_ack !== exp_ack) begin
            bad++;
            $display("FAIL rr_order i=%0d got=%b exp=%b", i, agent_ack, exp_ack);
         end
         if (agent_ack === 3'b010) cnt1++;
         if (agent_ack === 3'b100) cnt2++;
         @(negedge clk_ir);
      end
      agent_req = 3'b000;
      n_total++;
      if (bad != 0) $display("FAIL rr_alternate got %0d bad grants exp 0", bad); else n_pass++;
      n_total++;
      if (cnt1 != 10 || cnt2 != 10) $display("FAIL rr_count got %0d/%0d exp 10/10", cnt1, cnt2); else n_pass++;
      repeat (2) @(negedge clk_ir);
   endtask

   task automatic test_preempt();
      int bad = 0;
      @(negedge clk_ir);
      agent_req = 3'b111; agent_wr = 3'b000;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (agent_ack !== 3'b001) bad++;
         @(negedge clk_ir);
      end
      agent_req = 3'b110;
      n_total++;
      if (bad != 0) $display("FAIL pre_hold got %0d bad cycles exp 0", bad); else n_pass++;
      #1;
      n_total++;
      if (agent_ack !== 3'b010) $display("FAIL pre_release got=%b exp=010", agent_ack); else n_pass++;
      @(negedge clk_ir);
      agent_req = 3'b000;
      repeat (2) @(negedge clk_ir);
   endtask

   task automatic test_reset_mid_write();
      int bad = 0;
      @(negedge clk_ir);
      agent_req = 3'b010; agent_wr = 3'b010;
      agent_addr[1*AW +: AW] = 18'h00005; agent_wdata[1*DW +: DW] = 16'h5555;
      @(negedge clk_ir);
      agent_req = 3'b000; agent_wr = 3'b000;
      #1;
      n_total++;
      if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) $display("FAIL rmw_pre got we=%b dq=%b exp 0 1", sram_we_n, sram_dq_oe);
      else n_pass++;
      #2 rst_ih = 1'b1;
      #1;
      n_total++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_ce_n !== 1'b1 || agent_ack !== 3'b000)
         $display("FAIL rmw_async got we=%b dq=%b ce=%b ack=%b exp 1 0 1 000", sram_we_n, sram_dq_oe, sram_ce_n, agent_ack);
      else n_pass++;
      @(negedge clk_ir);
      rst_ih = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_ir);
         if (agent_rd_valid !== 3'b000 || agent_ack !== 3'b000 || sram_ce_n !== 1'b1) bad++;
      end
      n_total++;
      if (bad != 0) $display("FAIL rmw_after got %0d bad cycles exp 0", bad); else n_pass++;
      n_total++;
      if (mem[18'h00005] !== 16'h0000) $display("FAIL rmw_mem got=%h exp=0000", mem[18'h00005]); else n_pass++;
   endtask

   initial begin
      mem[18'h00010] = 16'hBEEF;
      mem[18'h00100] = 16'hA000;
      mem[18'h00101] = 16'hA001;
      mem[18'h00102] = 16'hA002;
      mem[18'h00005] = 16'h0000;
      test_reset();
      test_single_read();
      test_write_then_read();
      test_priority();
      test_round_robin();
      test_preempt();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
